p2_wb_queue: RTL and testbench

P2_WB_QUEUE -- requirements
Module: p2_wb_queue

---
 rtl/p2_wb_queue.sv | 81 ++++++++
 tb/tb_p2_wb_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/p2_wb_queue.sv
// Write-port-2 result queue: merges load-unit and multicycle-unit results into a
// circular FIFO that drains one entry per cycle into the register file.
module p2_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       ld_valid_i,
    input  logic [31:0]                ld_data_i,
    input  logic [5:0]                 ld_dest_i,
    output logic                       ld_ready_o,
    input  logic                       mc_valid_i,
    input  logic [31:0]                mc_data_i,
    input  logic [5:0]                 mc_dest_i,
    output logic                       mc_ready_o,
    output logic                       p2_we_o,
    output logic [31:0]                p2_we_data_o,
    output logic [5:0]                 p2_we_dest_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] mc_addr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [CW-1:0] push_cnt;
    logic          ld_push;
    logic          mc_push;
    logic          pop;

    logic [31:0] data_mem [DEPTH];
    logic [5:0]  dest_mem [DEPTH];

    // Credit comes from the registered count only; a pop this cycle frees nothing yet.
    assign free = rst_i ? CW'(DEPTH) : (CW'(DEPTH) - count);

    assign ld_ready_o = !flush_i && (free >= CW'(1));
    assign mc_ready_o = !flush_i && ((free >= CW'(2)) || ((free >= CW'(1)) && !ld_valid_i));

    // Destination 0 completes the handshake but is never stored.
    assign ld_push = !rst_i && ld_valid_i && ld_ready_o && (ld_dest_i != 6'd0);
    assign mc_push = !rst_i && mc_valid_i && mc_ready_o && (mc_dest_i != 6'd0);

    assign mc_addr  = ld_push ? (wr_ptr + AW'(1)) : wr_ptr;
    assign push_cnt = CW'(ld_push) + CW'(mc_push);

    assign p2_we_o      = (count != '0) && !flush_i && !rst_i;
    assign pop          = p2_we_o;
    assign p2_we_data_o = data_mem[rd_ptr];
    assign p2_we_dest_o = dest_mem[rd_ptr];
    assign count_o      = count;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + push_cnt[AW-1:0];
            count  <= count + push_cnt - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (ld_push) begin
            data_mem[wr_ptr] <= ld_data_i;
            dest_mem[wr_ptr] <= ld_dest_i;
        end
        if (mc_push) begin
            data_mem[mc_addr] <= mc_data_i;
            dest_mem[mc_addr] <= mc_dest_i;
        end
    end

endmodule

// File: tb/tb_p2_wb_queue.sv
// Bench for p2_wb_queue: queue-based reference model checked every negedge,
// plus directed scenarios with hand-computed expectations.
module tb_p2_wb_queue;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        ld_valid_i;
    logic [31:0] ld_data_i;
    logic [5:0]  ld_dest_i;
    logic        ld_ready_o;
    logic        mc_valid_i;
    logic [31:0] mc_data_i;
    logic [5:0]  mc_dest_i;
    logic        mc_ready_o;
    logic        p2_we_o;
    logic [31:0] p2_we_data_o;
    logic [5:0]  p2_we_dest_o;
    logic [2:0]  count_o;

    p2_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_dest_i(ld_dest_i),
        .ld_ready_o(ld_ready_o),
        .mc_valid_i(mc_valid_i), .mc_data_i(mc_data_i), .mc_dest_i(mc_dest_i),
        .mc_ready_o(mc_ready_o),
        .p2_we_o(p2_we_o), .p2_we_data_o(p2_we_data_o), .p2_we_dest_o(p2_we_dest_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 0;
    bit log_en   = 0;

    logic [37:0] mq[$];
    logic [5:0]  pop_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {dest,data}; pop head then append accepted pushes in order.
    int m_free;
    bit m_lr, m_mr;
    always @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            mq.delete();
        end else begin
            m_free = DEPTH - mq.size();
            m_lr = m_free >= 1;
            m_mr = (m_free >= 2) || (m_free >= 1 && !ld_valid_i);
            if (mq.size() != 0) void'(mq.pop_front());
            if (ld_valid_i && m_lr && ld_dest_i != 6'd0) mq.push_back({ld_dest_i, ld_data_i});
            if (mc_valid_i && m_mr && mc_dest_i != 6'd0) mq.push_back({mc_dest_i, mc_data_i});
        end
    end

    int  e_free;
    bit  e_we;
    always @(negedge clk_i) begin
        if (check_en) begin
            e_free = rst_i ? DEPTH : DEPTH - mq.size();
            e_we   = (mq.size() != 0) && !flush_i && !rst_i;
            chk("count_o", 32'(count_o), 32'(mq.size()));
            chk("p2_we_o", 32'(p2_we_o), 32'(e_we));
            chk("ld_ready_o", 32'(ld_ready_o), 32'(!flush_i && e_free >= 1));
            chk("mc_ready_o", 32'(mc_ready_o),
                32'(!flush_i && (e_free >= 2 || (e_free >= 1 && !ld_valid_i))));
            if (e_we) begin
                chk("p2_we_dest_o", 32'(p2_we_dest_o), 32'(mq[0][37:32]));
                chk("p2_we_data_o", p2_we_data_o, mq[0][31:0]);
            end
            if (log_en && p2_we_o) pop_log.push_back(p2_we_dest_o);
        end
    end

    task automatic setin(input logic lv, input logic [5:0] ldst, input logic [31:0] ldat,
                         input logic mv, input logic [5:0] mdst, input logic [31:0] mdat,
                         input logic fl, input logic rs);
        ld_valid_i = lv; ld_dest_i = ldst; ld_data_i = ldat;
        mc_valid_i = mv; mc_dest_i = mdst; mc_data_i = mdat;
        flush_i = fl; rst_i = rs;
        #2;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(); setin(0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic single_push_check();
        setin(1, 6'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("single_ld_ready", 32'(ld_ready_o), 1);
        tick();
        idle();
        chk("single_we", 32'(p2_we_o), 1);
        chk("single_dest", 32'(p2_we_dest_o), 5);
        chk("single_data", p2_we_data_o, 32'hDEADBEEF);
        chk("single_count", 32'(count_o), 1);
        tick();
        idle();
        chk("single_we_after", 32'(p2_we_o), 0);
        chk("single_count_after", 32'(count_o), 0);
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        idle();
        while (count_o != 0 && n < 10) begin
            tick();
            idle();
            n++;
        end
        chk(name, 32'(count_o), 0);
    endtask

    initial begin
        logic [5:0] exp_order [8];
        int li, mi, n;
        bit lacc, macc;
        exp_order = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7, 6'd6, 6'd8};

        setin(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check_en = 1;
        setin(0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_we", 32'(p2_we_o), 0);
        chk("reset_ld_ready", 32'(ld_ready_o), 1);
        chk("reset_mc_ready", 32'(mc_ready_o), 1);
        tick();
        idle();
        chk("reset_count", 32'(count_o), 0);

        single_push_check();

        // Both producers streaming: each holds its value until accepted.
        li = 0; mi = 0; n = 0;
        log_en = 1;
        while ((li < 4 || mi < 4) && n < 40) begin
            setin(li < 4, 6'(2 * li + 1), 32'h1000 + 32'(li),
                  mi < 4, 6'(2 * mi + 2), 32'h2000 + 32'(mi), 0, 0);
            if (li < 4 && DEPTH - mq.size() < 2) chk("stream_mc_blocked", 32'(mc_ready_o), 0);
            chk("stream_count_bound", 32'(count_o <= 3'd4), 1);
            lacc = ld_valid_i && ld_ready_o;
            macc = mc_valid_i && mc_ready_o;
            tick();
            if (lacc) li++;
            if (macc) mi++;
            n++;
        end
        chk("stream_done", 32'(li == 4 && mi == 4), 1);
        drain("stream_drain");
        log_en = 0;
        chk("stream_pop_count", 32'(pop_log.size()), 8);
        for (int i = 0; i < 8; i++)
            if (i < pop_log.size()) chk("stream_order", 32'(pop_log[i]), 32'(exp_order[i]));
        pop_log.delete();

        // Park pointers at 3, then burst so entries wrap around the end of storage.
        setin(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            setin(1, 6'(10 + i), 32'hA0 + 32'(i), 0, 0, 0, 0, 0);
            tick();
        end
        drain("wrap_predrain");
        log_en = 1;
        setin(1, 6'd20, 32'hB0, 1, 6'd21, 32'hB1, 0, 0);
        tick();
        setin(1, 6'd22, 32'hB2, 1, 6'd23, 32'hB3, 0, 0);
        chk("wrap_mc_ready_free2", 32'(mc_ready_o), 1);
        tick();
        setin(1, 6'd24, 32'hB4, 1, 6'd25, 32'hB5, 0, 0);
        chk("wrap_count3", 32'(count_o), 3);
        chk("wrap_mc_blocked", 32'(mc_ready_o), 0);
        tick();
        drain("wrap_drain");
        log_en = 0;
        chk("wrap_pop_count", 32'(pop_log.size()), 5);
        for (int i = 0; i < 5; i++)
            if (i < pop_log.size()) chk("wrap_order", 32'(pop_log[i]), 32'(20 + i));
        pop_log.delete();

        // Destination 0 is accepted and dropped.
        setin(0, 0, 0, 1, 6'd0, 32'h1234, 0, 0);
        chk("dest0_mc_ready", 32'(mc_ready_o), 1);
        tick();
        idle();
        chk("dest0_count", 32'(count_o), 0);
        chk("dest0_we", 32'(p2_we_o), 0);
        tick();

        // Flush with 3 entries queued and a load offered.
        setin(1, 6'd1, 32'h11, 1, 6'd2, 32'h22, 0, 0);
        tick();
        setin(1, 6'd3, 32'h33, 1, 6'd4, 32'h44, 0, 0);
        tick();
        setin(1, 6'd5, 32'h55, 0, 0, 0, 1, 0);
        chk("flush_count_before", 32'(count_o), 3);
        chk("flush_ld_ready", 32'(ld_ready_o), 0);
        chk("flush_we", 32'(p2_we_o), 0);
        tick();
        idle();
        chk("flush_count_after", 32'(count_o), 0);
        chk("flush_we_after", 32'(p2_we_o), 0);
        tick();

        // Reset beats flush with 2 entries queued.
        setin(1, 6'd7, 32'h77, 1, 6'd8, 32'h88, 0, 0);
        tick();
        setin(0, 0, 0, 0, 0, 0, 1, 1);
        chk("rst_count_before", 32'(count_o), 2);
        chk("rst_we", 32'(p2_we_o), 0);
        tick();
        idle();
        chk("rst_count_after", 32'(count_o), 0);
        chk("rst_we_after", 32'(p2_we_o), 0);
        tick();
        single_push_check();

        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
